// File: rtl/fetch_pair_buffer.sv
// rtl/fetch_pair_buffer.sv - instruction-pair FIFO between fetch and dual-issue decode
//
// Purpose:
//   Holds aligned instruction pairs, with their per-slot prediction bits and
//   pair PC, between fetch and decode. The oldest pair is presented
//   first-word-fall-through. Slot 1 is squashed on write when slot 0 is
//   predicted taken. A flush drops all buffered pairs.
//
// Optional feature (macro FETCH_PAIR_BUFFER_BYPASS_EN):
//   When the buffer is empty, an incoming pair is presented to decode in the
//   same cycle. If decode takes it, the pair is never written.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   fetch_valid_i           fetch offers a pair
//   fetch_pc_i              PC of slot 0 (slot 1 is PC+4)
//   fetch_inst0_i/1_i       slot instructions
//   fetch_pred_taken_0/1_i  slot predictions
//   fetch_ready_o           buffer can accept a pair
//   flush_i                 discard all entries and the offered pair
//   decode_stall_i          decode cannot consume the head pair
//   valid_o, pc_o, inst0_o, inst1_o, pred_taken_0_o, pred_taken_1_o
//                           head pair
//   count_o                 occupancy
module fetch_pair_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fetch_valid_i,
    input  logic [31:0]                fetch_pc_i,
    input  logic [31:0]                fetch_inst0_i,
    input  logic [31:0]                fetch_inst1_i,
    input  logic                       fetch_pred_taken_0_i,
    input  logic                       fetch_pred_taken_1_i,
    output logic                       fetch_ready_o,
    input  logic                       flush_i,
    input  logic                       decode_stall_i,
    output logic                       valid_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                inst0_o,
    output logic [31:0]                inst1_o,
    output logic                       pred_taken_0_o,
    output logic                       pred_taken_1_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pair storage; contents are don't-care until written.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] inst0_mem [DEPTH];
    logic [31:0] inst1_mem [DEPTH];
    logic        pred0_mem [DEPTH];
    logic        pred1_mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [31:0] in_inst1;
    logic        in_pred1;
    logic        bypass;
    logic        push;
    logic        pop;

    // Incoming pair after squash: a taken slot 0 kills slot 1.
    always_comb begin
        in_inst1 = fetch_pred_taken_0_i ? NOP_INST : fetch_inst1_i;
        in_pred1 = fetch_pred_taken_0_i ? 1'b0     : fetch_pred_taken_1_i;
    end

    always_comb begin
        fetch_ready_o = (count_q < CW'(DEPTH));
`ifdef FETCH_PAIR_BUFFER_BYPASS_EN
        bypass = (count_q == '0) && fetch_valid_i && !flush_i;
`else
        bypass = 1'b0;
`endif
        // A bypassed pair that decode takes immediately is never stored.
        push = fetch_valid_i && fetch_ready_o && !flush_i && !(bypass && !decode_stall_i);
        pop  = (count_q != '0) && !decode_stall_i && !flush_i;
    end

    // Head outputs: bypass path, stored head, or NOP when empty.
    always_comb begin
        valid_o = (count_q != '0) || bypass;
        count_o = count_q;
        if (bypass) begin
            pc_o           = fetch_pc_i;
            inst0_o        = fetch_inst0_i;
            inst1_o        = in_inst1;
            pred_taken_0_o = fetch_pred_taken_0_i;
            pred_taken_1_o = in_pred1;
        end else if (count_q != '0) begin
            pc_o           = pc_mem[rd_ptr_q];
            inst0_o        = inst0_mem[rd_ptr_q];
            inst1_o        = inst1_mem[rd_ptr_q];
            pred_taken_0_o = pred0_mem[rd_ptr_q];
            pred_taken_1_o = pred1_mem[rd_ptr_q];
        end else begin
            pc_o           = 32'h0;
            inst0_o        = NOP_INST;
            inst1_o        = NOP_INST;
            pred_taken_0_o = 1'b0;
            pred_taken_1_o = 1'b0;
        end
    end

    // Next-state: flush dominates; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_i;
            inst0_mem[wr_ptr_q] <= fetch_inst0_i;
            inst1_mem[wr_ptr_q] <= in_inst1;
            pred0_mem[wr_ptr_q] <= fetch_pred_taken_0_i;
            pred1_mem[wr_ptr_q] <= in_pred1;
        end
    end

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb/tb_fetch_pair_buffer.sv - self-checking bench for fetch_pair_buffer
module tb_fetch_pair_buffer;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef FETCH_PAIR_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fv = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [31:0]   fpc = '0, fi0 = '0, fi1 = '0;
    logic          fp0 = 1'b0, fp1 = 1'b0;
    logic          ready, valid, p0, p1;
    logic [31:0]   pc, i0, i1;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_en = 1'b0;

    always #5 clk = ~clk;

    fetch_pair_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fv), .fetch_pc_i(fpc),
        .fetch_inst0_i(fi0), .fetch_inst1_i(fi1),
        .fetch_pred_taken_0_i(fp0), .fetch_pred_taken_1_i(fp1),
        .fetch_ready_o(ready), .flush_i(flush), .decode_stall_i(stall),
        .valid_o(valid), .pc_o(pc), .inst0_o(i0), .inst1_o(i1),
        .pred_taken_0_o(p0), .pred_taken_1_o(p1), .count_o(count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        p0;
        logic        p1;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pairs; outputs and update follow the
    // pair-buffer rules directly from the current inputs.
    always @(negedge clk) begin
        if (model_en) begin
            ent_t inc, head;
            bit   byp, exp_valid, exp_ready;
            inc.pc = fpc;
            inc.i0 = fi0;
            inc.i1 = fp0 ? NOP : fi1;
            inc.p0 = fp0;
            inc.p1 = fp0 ? 1'b0 : fp1;
            exp_ready = (q.size() < DEPTH);
            byp = BYP && (q.size() == 0) && fv && !flush;
            exp_valid = (q.size() != 0) || byp;
            if (byp) head = inc;
            else if (q.size() != 0) head = q[0];
            else begin
                head.pc = 32'h0; head.i0 = NOP; head.i1 = NOP; head.p0 = 1'b0; head.p1 = 1'b0;
            end
            chk("valid", {31'b0, valid}, {31'b0, exp_valid});
            chk("ready", {31'b0, ready}, {31'b0, exp_ready});
            chk("count", 32'(count), 32'(q.size()));
            chk("pc", pc, head.pc);
            chk("inst0", i0, head.i0);
            chk("inst1", i1, head.i1);
            chk("pred0", {31'b0, p0}, {31'b0, head.p0});
            chk("pred1", {31'b0, p1}, {31'b0, head.p1});
            if (rst || flush) begin
                q.delete();
            end else if (!(byp && !stall)) begin
                if (exp_valid && !stall) void'(q.pop_front());
                if (fv && exp_ready) q.push_back(inc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic t0, input logic t1,
                          input logic s, input logic f);
        fv = v; fpc = a; fi0 = b; fi1 = c; fp0 = t0; fp1 = t1; stall = s; flush = f;
    endtask

    task automatic idle(input logic s);
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, s, 1'b0);
    endtask

    initial begin
        tick;
        tick;
        model_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_inst0", i0, NOP);
        chk("rst_pc", pc, 32'h0);

`ifndef FETCH_PAIR_BUFFER_BYPASS_EN
        set_in(1'b1, 32'h100, 32'h00500093, 32'h00A00113, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        idle(1'b0);
        #1;
        chk("t1_valid", {31'b0, valid}, 32'd1);
        chk("t1_pc", pc, 32'h100);
        chk("t1_inst0", i0, 32'h00500093);
        chk("t1_inst1", i1, 32'h00A00113);
        tick;
        chk("t1_empty_valid", {31'b0, valid}, 32'd0);
        chk("t1_empty_count", 32'(count), 32'd0);
`endif

        // Slot-1 squash
        set_in(1'b1, 32'h200, 32'h11111111, 32'h00100193, 1'b1, 1'b1, 1'b1, 1'b0);
        tick;
        idle(1'b1);
        #1;
        chk("sq_inst1", i1, NOP);
        chk("sq_pred1", {31'b0, p1}, 32'd0);
        chk("sq_pred0", {31'b0, p0}, 32'd1);
        chk("sq_inst0", i0, 32'h11111111);
        set_in(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        tick;

        // Fill to full under stall, then offer a fifth pair
        for (int k = 0; k < DEPTH; k++) begin
            set_in(1'b1, 32'h400 + 32'(16 * k), 32'hA000 + 32'(k), 32'hB000 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            tick;
        end
        idle(1'b1);
        #1;
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_ready", {31'b0, ready}, 32'd0);
        set_in(1'b1, 32'h4F0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        idle(1'b1);
        #1;
        chk("full_hold_count", 32'(count), 32'(DEPTH));
        idle(1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_pc", pc, 32'h400 + 32'(16 * k));
            tick;
        end
        chk("drain_count", 32'(count), 32'd0);

        // Three more across the pointer wrap
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h600 + 32'(16 * k), 32'hC000 + 32'(k), 32'hD000 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            tick;
        end
        idle(1'b1);
        #1;
        chk("wrap_count", 32'(count), 32'd3);
        chk("wrap_head", pc, 32'h600);
        idle(1'b0);
        tick;
        // count=2: simultaneous push and pop
        set_in(1'b1, 32'h700, 32'hE000, 32'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        idle(1'b1);
        #1;
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_head", pc, 32'h620);
        set_in(1'b1, 32'h710, 32'hE001, 32'hF001, 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        chk("pre_flush_count", 32'(count), 32'd3);
        // Flush with an offered pair
        set_in(1'b1, 32'h800, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        idle(1'b0);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", {31'b0, valid}, 32'd0);
        tick;
        chk("flush_drop", pc, 32'h0);

`ifdef FETCH_PAIR_BUFFER_BYPASS_EN
        set_in(1'b1, 32'h300, 32'h00500093, 32'h00A00113, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp_valid", {31'b0, valid}, 32'd1);
        chk("byp_pc", pc, 32'h300);
        chk("byp_count", 32'(count), 32'd0);
        tick;
        idle(1'b0);
        #1;
        chk("byp_after_count", 32'(count), 32'd0);
`endif

        // Randomised traffic with shifting stall pressure
        for (int n = 0; n < 3000; n++) begin
            int sb;
            sb = (n / 300) % 3;
            rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) < sb + 1, $urandom_range(0, 39) == 0);
            tick;
        end
        rst = 1'b0;
        idle(1'b0);
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pair_buffer.md
Name: fetch_pair_buffer

Overview:
- Instruction-pair FIFO between the fetch stage and the dual-issue decode stage.
- Captures aligned instruction pairs from fetch, together with their per-slot branch-prediction bits and the pair PC.
- Presents the oldest pair to decode in first-word-fall-through form and honours the decode stall.
- Squashes the slot after a predicted-taken slot 0, and drops all contents on a front-end flush.

Parameters:
- DEPTH, 4, number of pair entries; power of two, at least 2.
- NOP_INST, 32'h00000013, encoding substituted for squashed or empty slots (addi x0,x0,0).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- fetch_valid_i  input  1  fetch offers a pair this cycle.
- fetch_pc_i  input  32  PC of slot 0; slot 1 is PC+4.
- fetch_inst0_i  input  32  slot 0 instruction.
- fetch_inst1_i  input  32  slot 1 instruction.
- fetch_pred_taken_0_i  input  1  slot 0 predicted taken.
- fetch_pred_taken_1_i  input  1  slot 1 predicted taken.
- fetch_ready_o  output  1  buffer accepts a pair this cycle.
- flush_i  input  1  redirect/mispredict; discard all entries.
- decode_stall_i  input  1  decode cannot consume the head pair.
- valid_o  output  1  head pair valid.
- pc_o  output  32  head pair PC.
- inst0_o  output  32  head slot 0 instruction.
- inst1_o  output  32  head slot 1 instruction.
- pred_taken_0_o  output  1  head slot 0 prediction.
- pred_taken_1_o  output  1  head slot 1 prediction.
- count_o  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset state:
  - read/write pointers 0, count_o 0, valid_o 0, fetch_ready_o 1.
  - inst0_o/inst1_o = NOP_INST; pc_o 0; pred outputs 0.
- fetch_ready_o = (count < DEPTH); combinational from registered count only.
- Push: fetch_valid_i && fetch_ready_o && !flush_i.
  - Writes the entry at the write pointer; pointer increments modulo DEPTH (wrap-around).
  - No push into a full buffer, even when a pop happens in the same cycle.
- Slot-1 squash on write: if fetch_pred_taken_0_i = 1, the stored slot 1 is NOP_INST and its pred bit is 0. Slot 0 is stored unchanged.
- Pop: valid_o && !decode_stall_i && !flush_i; read pointer increments modulo DEPTH.
- Head outputs are combinational from the entry at the read pointer.
  - valid_o = (count != 0).
  - When empty: inst outputs NOP_INST, pred 0, pc 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency: a pushed pair is visible on the outputs the cycle after the push (without the bypass option).
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: pointers 0, count 0, valid_o 0.
  - The pair offered during the flush cycle is dropped.
- Reset asserted mid-operation behaves identically to flush; reset also wins over flush.
- decode_stall_i while empty has no effect.
- Storage contents need no reset; only pointers and count are reset.

Optional Feature:
- Macro: FETCH_PAIR_BUFFER_BYPASS_EN.
- Defined: when count = 0 and a push occurs (fetch_valid_i=1, flush_i=0):
  - the incoming pair (post-squash) drives the outputs combinationally and valid_o=1 in the same cycle.
  - If decode_stall_i=0 it is consumed directly: not written, count stays 0.
  - If decode_stall_i=1 it is written normally.
- Not defined: no bypass; minimum fetch-to-decode latency is one cycle.

Test Plan:
- Reset, then push pc=0x100, inst0=0x00500093, inst1=0x00A00113, preds 0/0 with stall=0 -> next cycle valid_o=1 with the same values; the following cycle valid_o=0, count_o=0.
- Push pc=0x200 with pred_taken_0=1, inst1=0x00100193, pred1=1 -> head shows inst1_o=0x00000013, pred_taken_1_o=0, pred_taken_0_o=1.
- Hold decode_stall_i=1 and push 4 pairs (DEPTH=4) -> count_o=4, fetch_ready_o=0. A 5th offered pair is not stored. Release stall -> pairs pop in order over 4 cycles, with read-pointer wrap verified by then pushing 3 more.
- With count=2, push and pop in the same cycle -> count_o stays 2, head advances to the second pair.
- With count=3, assert flush_i together with fetch_valid_i and stall=0 -> next cycle count_o=0, valid_o=0; the dropped pair never appears.
- FETCH_PAIR_BUFFER_BYPASS_EN defined, empty, push pc=0x300, stall=0 -> valid_o=1 and pc_o=0x300 in the same cycle, count_o remains 0.
